// File: rtl/hilo_muldiv.sv
// Iterative HI/LO multiply/divide unit: one shift-add (multiply) or restoring
// shift-subtract (divide) step per cycle on operand magnitudes, signs fixed at the end.
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             write,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_bzero;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_opd;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_busy;
    logic                 r_write;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) as unsigned.
    logic                 w_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    // Multiply step: r_acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]       w_madd;
    logic [2*WIDTH-1:0]   w_mul_next;

    assign w_madd     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_madd, r_acc[WIDTH-1:1]};

    // Divide step: r_acc = {partial remainder, dividend bits / quotient bits}.
    // A set top bit in the shifted remainder means it already exceeds any divisor.
    logic [WIDTH:0]       w_shift;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_sub;
    logic [2*WIDTH-1:0]   w_div_next;

    assign w_shift    = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge       = w_shift[WIDTH] | (w_shift[WIDTH-1:0] >= r_opd);
    assign w_sub      = w_shift[WIDTH-1:0] - r_opd;
    assign w_div_next = w_ge ? {w_sub, r_acc[WIDTH-2:0], 1'b1}
                             : {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // NOTE: state updates use non-blocking assignments so every register samples
    // pre-edge values; reset is tested first inside the clocked block (synchronous).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_bzero  <= 1'b0;
            r_a      <= '0;
            r_opd    <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_write  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_CALC;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_is_div <= op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_bzero  <= (b == '0);
                        r_a      <= a;
                        r_opd    <= op[1] ? w_b_mag : w_a_mag;
                        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
                    end
                end
                S_CALC: begin
                    if (r_cnt == CW'(WIDTH)) begin
                        r_state <= S_DONE;
                        r_write <= 1'b1;
                        if (!r_is_div) begin
                            {r_hi, r_lo} <= w_prod;
                        end else if (r_bzero) begin
                            r_hi <= r_a;
                            r_lo <= '1;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                    end else begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign write = r_write;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized scoreboard bench for hilo_muldiv: the driver predicts acceptance and
// pushes expected {hi,lo}; a negedge monitor checks write timing, busy and results.
module tb_hilo_muldiv;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_V = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         write;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    hilo_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .write (write),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] exp;
        int             acc;
    } sb_t;

    typedef struct {
        logic [1:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    sb_t            sb_q[$];
    int             cyc = 0;
    int             total = 0;
    int             bad = 0;
    int             next_ok = 0;
    bit             mon_en = 1'b0;
    logic [2*W-1:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour from the arithmetic rules, not from the datapath.
    function automatic logic [2*W-1:0] model(input logic [1:0] m_op, input logic [W-1:0] m_a,
                                            input logic [W-1:0] m_b);
        longint         sa, sb, q, r;
        logic [2*W-1:0] p;
        sa = longint'($signed(m_a));
        sb = longint'($signed(m_b));
        case (m_op)
            2'b00: begin
                p = 64'(sa * sb);
                return p;
            end
            2'b01: begin
                p = {32'd0, m_a} * {32'd0, m_b};
                return p;
            end
            default: begin
                if (m_b == '0) return {m_a, 32'hFFFF_FFFF};
                if (m_op == 2'b11) return {m_a % m_b, m_a / m_b};
                if (m_a == MIN_V && m_b == 32'hFFFF_FFFF) return {32'd0, MIN_V};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return MIN_V;
            4: return 32'(($urandom_range(0, 1) != 0) ? -$urandom_range(1, 40) : $urandom_range(1, 40));
            default: return $urandom;
        endcase
    endfunction

    // Waits for the first edge at which the DUT is predicted idle, issues the op there,
    // then scrambles the inputs so latching is exercised. noise toggles start while busy.
    task automatic run_op(input logic [1:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                          input logic [2*W-1:0] t_exp, input bit hold, input bit noise,
                          output int acc);
        sb_t e;
        @(posedge clk);
        #1;
        while (cyc + 1 < next_ok) begin
            start = noise ? 1'($urandom_range(0, 1)) : hold;
            op    = 2'($urandom);
            a     = $urandom;
            b     = $urandom;
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        op    = t_op;
        a     = t_a;
        b     = t_b;
        acc   = cyc + 1;
        e.exp = t_exp;
        e.acc = acc;
        sb_q.push_back(e);
        next_ok = acc + W + 3;
        @(posedge clk);
        #1;
        start = hold;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb_q.size() > 0 && cyc > sb_q[0].acc + W + 1) begin
                check("write_timeout", 64'(cyc), 64'(sb_q[0].acc + W + 1));
                void'(sb_q.pop_front());
            end
            check("busy", 64'(busy), 64'((sb_q.size() > 0 && cyc >= sb_q[0].acc) ? 1 : 0));
            if (write === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_write", 64'(write), 64'(0));
                end else begin
                    check("write_cycle", 64'(cyc), 64'(sb_q[0].acc + W + 1));
                    check("result", {hi, lo}, sb_q[0].exp);
                    last_res = sb_q[0].exp;
                    void'(sb_q.pop_front());
                end
            end else begin
                check("hold_stable", {hi, lo}, last_res);
            end
        end
    end

    vec_t dir_v[8];
    int   acc_n;

    initial begin
        dir_v[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        dir_v[1] = '{2'b00, 32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1};
        dir_v[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        dir_v[3] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD};
        dir_v[4] = '{2'b11, 32'd7,         32'd2,         64'h0000_0001_0000_0003};
        dir_v[5] = '{2'b11, 32'd7,         32'd0,         64'h0000_0007_FFFF_FFFF};
        dir_v[6] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        dir_v[7] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",  64'(busy),  64'(0));
        check("reset_write", 64'(write), 64'(0));
        check("reset_hilo",  {hi, lo},   64'(0));
        reset   = 1'b0;
        next_ok = cyc + 1;
        mon_en  = 1'b1;

        foreach (dir_v[i]) run_op(dir_v[i].op, dir_v[i].a, dir_v[i].b, dir_v[i].exp, 1'b0, 1'b1, acc_n);

        // Start held high: back-to-back operations at the first idle edge each time.
        for (int i = 0; i < 3; i++) begin
            logic [1:0]   r_op;
            logic [W-1:0] r_a, r_b;
            r_op = 2'($urandom);
            r_a  = rnd_val();
            r_b  = rnd_val();
            run_op(r_op, r_a, r_b, model(r_op, r_a, r_b), 1'b1, 1'b0, acc_n);
        end

        // Reset in the tenth CALC cycle aborts the operation without a write.
        run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 64'd0, 1'b0, 1'b0, acc_n);
        while (cyc < acc_n + 9) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        last_res = '0;
        next_ok  = cyc + 1;
        check("abort_busy",  64'(busy),  64'(0));
        check("abort_write", 64'(write), 64'(0));
        check("abort_hilo",  {hi, lo},   64'(0));

        run_op(2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0, 1'b0, acc_n);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]   r_op;
            logic [W-1:0] r_a, r_b;
            r_op = 2'($urandom);
            r_a  = rnd_val();
            r_b  = rnd_val();
            run_op(r_op, r_a, r_b, model(r_op, r_a, r_b), 1'($urandom_range(0, 1)), 1'b1, acc_n);
        end

        start = 1'b0;
        while (cyc < next_ok + 2) begin
            @(posedge clk);
            #1;
        end
        mon_en = 1'b0;
        check("drain", 64'(sb_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
